dec_rr_arbiter: RTL and testbench

DEC_RR_ARBITER -- requirements
Module: dec_rr_arbiter

---
 rtl/dec_rr_arbiter_pkg.sv | 36 +++
 rtl/dec_rr_arbiter_decoder_3_8.sv | 20 ++
 rtl/dec_rr_arbiter.sv | 93 +++++++++
 tb/tb_dec_rr_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/dec_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dec_rr_arbiter_pkg
// Shared constants for the decoded round-robin arbiter.
//   state_t  : FSM state encoding (IDLE / GRANT)
//   GRANT_W  : number of requesters / width of the one-hot grant
//   IDX_W    : width of a requester index
//   rr_pick  : round-robin winner search starting at a pointer
// ---------------------------------------------------------------------------
package dec_rr_arbiter_pkg;

    localparam int GRANT_W = 8;
    localparam int IDX_W   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Returns the first set request at or above ptr, wrapping past the top
    // requester back to 0. Scanning from the far end downward lets the
    // nearest candidate overwrite the rest, so no early exit is needed.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [GRANT_W-1:0] req,
                                                 input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] j;
        pick = ptr;
        for (int k = GRANT_W - 1; k >= 0; k--) begin
            j = ptr + IDX_W'(k);
            if (req[j]) begin
                pick = j;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/dec_rr_arbiter_decoder_3_8.sv
// ---------------------------------------------------------------------------
// decoder_3_8
// Combinational 3-to-8 one-hot decoder.
//   in1 : select bit 2 (MSB)
//   in2 : select bit 1
//   in3 : select bit 0 (LSB)
//   out : one-hot decode of {in1,in2,in3}
// ---------------------------------------------------------------------------
module decoder_3_8
    import dec_rr_arbiter_pkg::*;
(
    input  logic               in1,
    input  logic               in2,
    input  logic               in3,
    output logic [GRANT_W-1:0] out
);

    assign out = GRANT_W'(1) << {in1, in2, in3};

endmodule

// File: rtl/dec_rr_arbiter.sv
// ---------------------------------------------------------------------------
// dec_rr_arbiter
// Eight-requester round-robin arbiter with a bounded grant slot. The winner
// index is presented on the decoder select lines and as a one-hot grant.
//   SLOT_MAX  : last slot counter value; a grant lasts at most SLOT_MAX+1 cycles
//   sys_clk   : clock, rising edge
//   sys_rst_n : asynchronous active-low reset
//   req       : level-sensitive request lines, bit i = requester i
//   in1..in3  : registered winner index (MSB..LSB), 000 while idle
//   grant     : one-hot grant, 8'h00 while idle
//   busy      : high while a grant is active
// ---------------------------------------------------------------------------
module dec_rr_arbiter
    import dec_rr_arbiter_pkg::*;
#(
    parameter logic [15:0] SLOT_MAX = 16'd999
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [GRANT_W-1:0] req,
    output logic               in1,
    output logic               in2,
    output logic               in3,
    output logic [GRANT_W-1:0] grant,
    output logic               busy
);

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   sel;
    logic [15:0]        cnt;
    logic               busy_r;
    logic [GRANT_W-1:0] dec_out;

    // sel mirrors idx during a grant and is forced to zero while idle, so the
    // select outputs come straight from a register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state  <= IDLE;
            ptr    <= '0;
            idx    <= '0;
            sel    <= '0;
            cnt    <= '0;
            busy_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req != '0) begin
                        state  <= GRANT;
                        idx    <= rr_pick(req, ptr);
                        sel    <= rr_pick(req, ptr);
                        cnt    <= '0;
                        busy_r <= 1'b1;
                    end
                end
                GRANT: begin
                    // Only the owner's request line matters here; a drop and
                    // slot expiry on the same edge collapse into one release.
                    if (!req[idx] || (cnt == SLOT_MAX)) begin
                        state  <= IDLE;
                        sel    <= '0;
                        busy_r <= 1'b0;
                        ptr    <= idx + IDX_W'(1);
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    sel    <= '0;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    decoder_3_8 u_dec (
        .in1 (sel[2]),
        .in2 (sel[1]),
        .in3 (sel[0]),
        .out (dec_out)
    );

    // busy_r clears asynchronously on reset, so gating here drops grant
    // without waiting for a clock edge.
    assign grant = dec_out & {GRANT_W{busy_r}};
    assign busy  = busy_r;
    assign in1   = sel[2];
    assign in2   = sel[1];
    assign in3   = sel[0];

endmodule

// File: tb/tb_dec_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dec_rr_arbiter
// Scoreboard bench for dec_rr_arbiter with SLOT_MAX=4. A reference model
// tracks which requester owns the slot and for how many cycles; each clock
// edge pushes the expected outputs, and a monitor compares them against the
// DUT on the falling edge.
// ---------------------------------------------------------------------------
module tb_dec_rr_arbiter;

    localparam logic [15:0] SLOT = 16'd4;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic [7:0] req;
    logic       in1, in2, in3;
    logic [7:0] grant;
    logic       busy;

    dec_rr_arbiter #(.SLOT_MAX(SLOT)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .req       (req),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [7:0] g;
        logic       b;
        logic [2:0] s;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: owner of the slot (-1 when nobody), cycles held so
    // far including the current one, and the next search start.
    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 0;

    function automatic exp_t model_out();
        exp_t e;
        if (m_owner < 0) begin
            e.g = 8'h00;
            e.b = 1'b0;
            e.s = 3'd0;
        end else begin
            e.g = 8'h01 << m_owner;
            e.b = 1'b1;
            e.s = 3'(m_owner);
        end
        return e;
    endfunction

    task automatic model_step(input logic [7:0] r);
        bit found;
        int j;
        if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 0; k < 8; k++) begin
                j = (m_ptr + k) % 8;
                if (!found && r[j]) begin
                    m_owner = j;
                    found   = 1'b1;
                end
            end
            m_held = 1;
        end else if (!r[m_owner] || (m_held == int'(SLOT) + 1)) begin
            m_ptr   = (m_owner + 1) % 8;
            m_owner = -1;
        end else begin
            m_held++;
        end
    endtask

    task automatic cycle(input logic [7:0] r);
        @(negedge sys_clk);
        req = r;
        @(posedge sys_clk);
        model_step(r);
        expq.push_back(model_out());
    endtask

    // Reset is asserted between edges so the monitor can see grant drop
    // before any clock edge; the first edge after release is modelled too.
    task automatic do_reset(input logic [7:0] r, input int n);
        @(negedge sys_clk);
        #2;
        req       = r;
        sys_rst_n = 1'b0;
        expq.delete();
        m_owner = -1;
        m_held  = 0;
        m_ptr   = 0;
        repeat (n) @(negedge sys_clk);
        #2;
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        model_step(req);
        expq.push_back(model_out());
    endtask

    exp_t e_mon;

    always begin
        @(negedge sys_clk or negedge sys_rst_n);
        #1;
        if (!sys_rst_n) begin
            checks++;
            if (grant !== 8'h00 || busy !== 1'b0 || {in1, in2, in3} !== 3'b000) begin
                errors++;
                $display("FAIL reset_outputs t=%0t: grant=%h busy=%b sel=%b, required 00/0/000",
                         $time, grant, busy, {in1, in2, in3});
            end
        end else if (expq.size() > 0) begin
            e_mon = expq.pop_front();
            checks++;
            if ({grant, busy, in1, in2, in3} !== e_mon) begin
                errors++;
                $display("FAIL scoreboard t=%0t: grant=%h busy=%b sel=%b, required grant=%h busy=%b sel=%b",
                         $time, grant, busy, {in1, in2, in3}, e_mon.g, e_mon.b, e_mon.s);
            end
        end else if (busy !== 1'b0 || grant !== 8'h00) begin
            checks++;
            errors++;
            $display("FAIL unexpected_grant t=%0t: grant=%h busy=%b with nothing expected",
                     $time, grant, busy);
        end
    end

    logic [7:0] rnd;

    initial begin
        sys_rst_n = 1'b0;
        req       = 8'hFF;

        // Reset held with every requester asserted.
        do_reset(8'hFF, 3);

        // Single holder on requester 5.
        repeat (14) cycle(8'h20);

        // Everyone requesting: full rotation and wrap to requester 0.
        do_reset(8'hFF, 2);
        repeat (52) cycle(8'hFF);

        // Early drop after two cycles.
        do_reset(8'h00, 2);
        cycle(8'h04);
        cycle(8'h04);
        repeat (4) cycle(8'h00);

        // Wrap past requester 7.
        do_reset(8'h00, 2);
        repeat (3) cycle(8'h80);
        repeat (2) cycle(8'h00);
        repeat (14) cycle(8'h41);

        // Reset in the middle of a grant to requester 3.
        do_reset(8'h00, 1);
        repeat (3) cycle(8'h08);
        do_reset(8'h08, 2);
        repeat (4) cycle(8'h08);

        // Randomized traffic with sticky request patterns.
        rnd = 8'h00;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                rnd = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
            end
            if (i == 200) begin
                do_reset(rnd, 1);
            end
            cycle(rnd);
        end

        @(negedge sys_clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
